// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_ctrl_if : handshake bundle between pipeline and fetch_ctrl    |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
interface fetch_ctrl_if;
   logic        br_taken;
   logic [31:0] br_target;
   logic        load_use;
   logic        imem_ready;
   logic        halt_req;
   logic        is_flush;
   logic        is_stall;
   logic [31:0] branch_target;
   logic        halted;
   logic [15:0] flush_count;
   logic [15:0] stall_count;

   modport master (
      output br_taken, br_target, load_use, imem_ready, halt_req,
      input  is_flush, is_stall, branch_target, halted, flush_count, stall_count
   );

   modport slave (
      input  br_taken, br_target, load_use, imem_ready, halt_req,
      output is_flush, is_stall, branch_target, halted, flush_count, stall_count
   );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_ctrl : IF-stage stall/flush controller (BOOT/RUN/FLUSH/HALT)  |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
module fetch_ctrl #(
   parameter int BOOT_CYCLES = 2,
   parameter int FLUSH_DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   fetch_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);

   state_t      state_q;
   logic [3:0]  boot_cnt_q;
   logic [2:0]  flush_cnt_q;
   logic [31:0] branch_target_q;
   logic [15:0] flush_count_q;
   logic [15:0] stall_count_q;
   logic        halted_q;

   logic        accept;
   logic        stall;

   // A redirect in FLUSH is always taken; in RUN it needs the fetch to complete.
   always_comb begin
      accept = 1'b0;
      stall  = 1'b1;
      case (state_q)
         ST_BOOT:  stall = 1'b1;
         ST_RUN: begin
            accept = bus.br_taken & bus.imem_ready;
            stall  = accept ? 1'b0 : (bus.load_use | ~bus.imem_ready);
         end
         ST_FLUSH: begin
            accept = bus.br_taken;
            stall  = 1'b0;
         end
         ST_HALT:  stall = 1'b1;
         default:  stall = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= ST_BOOT;
         boot_cnt_q      <= 4'd0;
         flush_cnt_q     <= 3'd0;
         branch_target_q <= 32'h0;
         flush_count_q   <= 16'h0;
         stall_count_q   <= 16'h0;
         halted_q        <= 1'b0;
      end else begin
         if (accept) begin
            branch_target_q <= bus.br_target;
            flush_cnt_q     <= FLUSH_LOAD;
            state_q         <= ST_FLUSH;
            if (!(&flush_count_q)) flush_count_q <= flush_count_q + 16'd1;
         end

         if ((state_q == ST_RUN) && stall && !(&stall_count_q))
            stall_count_q <= stall_count_q + 16'd1;

         case (state_q)
            ST_BOOT: begin
               if (boot_cnt_q == BOOT_LAST) begin
                  boot_cnt_q <= 4'd0;
                  state_q    <= ST_RUN;
               end else begin
                  boot_cnt_q <= boot_cnt_q + 4'd1;
               end
            end
            ST_RUN: begin
               if (!accept && bus.halt_req) begin
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
               end
            end
            ST_FLUSH: begin
               if (!accept) begin
                  if (flush_cnt_q == 3'd0) state_q <= ST_RUN;
                  else                     flush_cnt_q <= flush_cnt_q - 3'd1;
               end
            end
            ST_HALT: ;
            default: state_q <= ST_BOOT;
         endcase
      end
   end

   assign bus.is_stall      = stall;
   assign bus.is_flush      = (state_q == ST_FLUSH);
   assign bus.branch_target = branch_target_q;
   assign bus.halted        = halted_q;
   assign bus.flush_count   = flush_count_q;
   assign bus.stall_count   = stall_count_q;

endmodule
`default_nettype wire
